uart_frame_rx: RTL and testbench

- Parametrised asynchronous-serial frame receiver; successor to the fixed 8-bit receiver that feeds ViterbiDecoder.
- Configurable data width, bit period and parity mode.
- Start-bit validation, stop/parity error detection, and a small FIFO with a valid/ready output handshake.
- Sits between the rx pin and the decoder, or any other byte consumer.

---
 rtl/uart_frame_rx.sv | 234 +++++++++++++++++++++++
 tb/tb_uart_frame_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: parametrised asynchronous-serial frame receiver.
// Two-flop synchronised rx drives a frame FSM (start validation, LSB-first
// data, optional parity, stop check) that pushes good frames into a small
// first-word-fall-through FIFO with a valid/ready output.
// Optional build macro: UART_RX_MAJORITY_EN -- every sample point takes a
// 3-sample majority vote, with the decision registered one cycle later.
module uart_frame_rx #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        start,
    input  logic                        rx,
    output logic [DATA_BITS-1:0]        out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        framing_err,
    output logic                        parity_err,
    output logic                        overrun
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT + 2) + 1;
    localparam int BW = $clog2(DATA_BITS + 1);

`ifdef UART_RX_MAJORITY_EN
    // The vote needs the sample after s, so each decision lands one cycle late.
    localparam int VOTE_LAG = 1;
`else
    localparam int VOTE_LAG = 0;
`endif

    // Counter values at which the start bit and every later bit are decided.
    localparam logic [CW-1:0] START_POINT = CW'(CLKS_PER_BIT / 2 + VOTE_LAG);
    localparam logic [CW-1:0] BIT_POINT   = CW'(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    // Parity bit the line must carry for a given payload.
    function automatic logic expected_parity(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_MODE == 2);
    endfunction

    logic rx_meta_p0;
    logic rx_s;
    logic rx_bit;

    // Stage p0/p1: two-flop synchroniser; idle level is high.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rx;
            rx_s       <= rx_meta_p0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic rx_dly_p2;
    logic rx_dly_p3;

    // Majority of three adjacent synchronised samples.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Stage p2/p3: history of rx_s for the vote (s-1 and s when rx_s is s+1).
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            rx_dly_p2 <= 1'b1;
            rx_dly_p3 <= 1'b1;
        end else begin
            rx_dly_p2 <= rx_s;
            rx_dly_p3 <= rx_dly_p2;
        end
    end

    assign rx_bit = maj3(rx_dly_p3, rx_dly_p2, rx_s);
`else
    assign rx_bit = rx_s;
`endif

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 push_req;

    // Frame FSM: counts bit periods from the start edge, samples each bit,
    // and issues registered push / error pulses after the stop sample.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state       <= S_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bit     <= 1'b0;
            push_req    <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
        end else begin
            push_req    <= 1'b0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    // cnt reads 1 on the first cycle after the falling edge.
                    cnt     <= CW'(1);
                    bit_idx <= '0;
                    if (!rx_s) begin
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == START_POINT) begin
                        cnt   <= CW'(1);
                        state <= rx_bit ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_POINT) begin
                        cnt     <= CW'(1);
                        shreg   <= {rx_bit, shreg[DATA_BITS-1:1]};
                        bit_idx <= bit_idx + BW'(1);
                        if (bit_idx == BW'(DATA_BITS - 1)) begin
                            state <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt == BIT_POINT) begin
                        cnt     <= CW'(1);
                        par_bit <= rx_bit;
                        state   <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_POINT) begin
                        cnt <= CW'(1);
                        if (!rx_bit) begin
                            // A low stop bit may be a break; wait for the line to recover.
                            framing_err <= 1'b1;
                            state       <= S_WAIT_IDLE;
                        end else if ((PARITY_MODE != 0) && (par_bit != expected_parity(shreg))) begin
                            parity_err <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            push_req <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [LW-1:0]        level;
    logic                 full;
    logic                 pop;
    logic                 do_push;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = out_valid && out_ready;
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push_req && (!full || pop);

    // FIFO control: pointers wrap naturally at a power-of-two depth.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            overrun <= 1'b0;
        end else begin
            overrun <= push_req && full && !pop;
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // FIFO storage: payload written from the shift register, which holds
    // still until the next frame's first data bit.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= shreg;
        end
    end

    assign out_valid  = (level != '0);
    assign fifo_level = level;
    assign out_data   = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed plus randomised frames against two receivers
// (8N1 defaults and 8E1), with expectations derived from the frame rules.
`timescale 1ns/1ps
module tb_uart_frame_rx;
    localparam int CPB   = 10;
    localparam int DB    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          start = 1'b0;
    logic          rx0 = 1'b1;
    logic          rx1 = 1'b1;
    logic          out_ready = 1'b1;
    logic [DB-1:0] data0, data1;
    logic          valid0, valid1;
    logic [2:0]    level0, level1;
    logic          ferr0, perr0, ovr0;
    logic          ferr1, perr1, ovr1;

    always #5 clk = ~clk;

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(0), .FIFO_DEPTH(DEPTH)) dut0 (
        .clk(clk), .start(start), .rx(rx0), .out_data(data0), .out_valid(valid0),
        .out_ready(out_ready), .fifo_level(level0), .framing_err(ferr0),
        .parity_err(perr0), .overrun(ovr0)
    );

    uart_frame_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY_MODE(1), .FIFO_DEPTH(DEPTH)) dut1 (
        .clk(clk), .start(start), .rx(rx1), .out_data(data1), .out_valid(valid1),
        .out_ready(out_ready), .fifo_level(level1), .framing_err(ferr1),
        .parity_err(perr1), .overrun(ovr1)
    );

    int total = 0;
    int bad = 0;

    // Monitor: record every accepted word and every error pulse.
    logic [7:0] got0[$];
    logic [7:0] got1[$];
    int fcnt0 = 0, pcnt0 = 0, ocnt0 = 0;
    int fcnt1 = 0, pcnt1 = 0, ocnt1 = 0;

    always @(negedge clk) begin
        if (valid0 && out_ready) got0.push_back(data0);
        if (valid1 && out_ready) got1.push_back(data1);
        if (ferr0) fcnt0++;
        if (perr0) pcnt0++;
        if (ovr0)  ocnt0++;
        if (ferr1) fcnt1++;
        if (perr1) pcnt1++;
        if (ovr1)  ocnt1++;
    end

    // Baselines so each test looks only at its own activity.
    int bg0, bg1, bf0, bp0, bo0, bf1, bp1, bo1;

    task automatic mark();
        bg0 = got0.size(); bg1 = got1.size();
        bf0 = fcnt0; bp0 = pcnt0; bo0 = ocnt0;
        bf1 = fcnt1; bp1 = pcnt1; bo1 = ocnt1;
    endtask

    function automatic logic [31:0] got_at(input int which, input int idx);
        if (which == 0) return (idx < got0.size()) ? 32'(got0[idx]) : 32'hDEADBEEF;
        return (idx < got1.size()) ? 32'(got1[idx]) : 32'hDEADBEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_rx(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic hold(input int which, input logic v, input int cycles);
        set_rx(which, v);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    // One frame: start, LSB-first data (optional 1-cycle mid-bit glitch),
    // optional parity, stop level held for stop_periods, then idle high.
    task automatic send_frame(input int which, input logic [7:0] d, input bit has_par,
                              input logic par, input logic stop_lvl, input int stop_periods,
                              input int idle_periods, input int glitch_bit);
        hold(which, 1'b0, CPB);
        for (int k = 0; k < DB; k++) begin
            if (k == glitch_bit) begin
                hold(which, d[k], CPB / 2);
                hold(which, ~d[k], 1);
                hold(which, d[k], CPB - CPB / 2 - 1);
            end else begin
                hold(which, d[k], CPB);
            end
        end
        if (has_par) hold(which, par, CPB);
        hold(which, stop_lvl, CPB * stop_periods);
        if (idle_periods > 0) hold(which, 1'b1, CPB * idle_periods);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [7:0] r;
    logic [7:0] exp_q[$];
    int exp_f, exp_p, kind, gb, idle;
    logic par, stop_lvl;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid0", 32'(valid0), 32'd0);
        check("rst_level0", 32'(level0), 32'd0);
        check("rst_data0", 32'(data0), 32'd0);
        check("rst_err0", 32'({ferr0, perr0, ovr0}), 32'd0);
        check("rst_valid1", 32'(valid1), 32'd0);
        start = 1'b1;
        hold(0, 1'b1, CPB);

        // 8N1 0xA5
        mark();
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1, 1, 2, -1);
        check("a5_beats", got0.size() - bg0, 1);
        check("a5_data", got_at(0, bg0), 32'hA5);
        check("a5_err", 32'((fcnt0 - bf0) + (pcnt0 - bp0) + (ocnt0 - bo0)), 32'd0);
        check("a5_level", 32'(level0), 32'd0);

        // Short low pulse is rejected as a false start
        mark();
        hold(0, 1'b0, 3);
        hold(0, 1'b1, 2 * CPB);
        check("glitch_beats", got0.size() - bg0, 0);
        check("glitch_err", 32'((fcnt0 - bf0) + (pcnt0 - bp0)), 32'd0);
        r = 8'($urandom_range(0, 255));
        send_frame(0, r, 1'b0, 1'b0, 1'b1, 1, 2, -1);
        check("after_glitch_data", got_at(0, bg0), 32'(r));
`ifdef UART_RX_MAJORITY_EN
        mark();
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1, 2, 2);
        check("vote_data", got_at(0, bg0), 32'h3C);
        check("vote_beats", got0.size() - bg0, 1);
`endif

        // Even parity: 0x03 carries parity 0
        mark();
        send_frame(1, 8'h03, 1'b1, 1'b1, 1'b1, 1, 2, -1);
        check("par_bad_pulse", 32'(pcnt1 - bp1), 32'd1);
        check("par_bad_level", 32'(level1), 32'd0);
        check("par_bad_beats", got1.size() - bg1, 0);
        mark();
        send_frame(1, 8'h03, 1'b1, 1'b0, 1'b1, 1, 2, -1);
        check("par_ok_data", got_at(1, bg1), 32'h03);
        check("par_ok_pulse", 32'(pcnt1 - bp1), 32'd0);

        // Stop bit low for three periods (break)
        mark();
        send_frame(0, 8'hC3, 1'b0, 1'b0, 1'b0, 3, 1, -1);
        check("frm_pulse", 32'(fcnt0 - bf0), 32'd1);
        check("frm_beats", got0.size() - bg0, 0);
        check("frm_level", 32'(level0), 32'd0);
        mark();
        send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, 1, 2, -1);
        check("frm_next_data", got_at(0, bg0), 32'h5A);
        check("frm_next_pulse", 32'(fcnt0 - bf0), 32'd0);

        // FIFO fill, overrun and drain
        out_ready = 1'b0;
        mark();
        for (int i = 1; i <= 5; i++) begin
            send_frame(0, 8'(i * 8'h11), 1'b0, 1'b0, 1'b1, 1, 0, -1);
        end
        hold(0, 1'b1, 2 * CPB);
        check("full_level", 32'(level0), 32'd4);
        check("full_overrun", 32'(ocnt0 - bo0), 32'd1);
        check("full_valid", 32'(valid0), 32'd1);
        check("full_head", 32'(data0), 32'h11);
        hold(0, 1'b1, 5);
        check("full_head_stable", 32'(data0), 32'h11);
        out_ready = 1'b1;
        hold(0, 1'b1, CPB);
        check("drain_beats", got0.size() - bg0, 4);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", got_at(0, bg0 + i), 32'((i + 1) * 8'h11));
        end
        check("drain_level", 32'(level0), 32'd0);

        // Asynchronous reset in the middle of a frame
        out_ready = 1'b0;
        send_frame(0, 8'h42, 1'b0, 1'b0, 1'b1, 1, 1, -1);
        check("prerst_level", 32'(level0), 32'd1);
        r = 8'h7E;
        hold(0, 1'b0, CPB);
        for (int k = 0; k < 3; k++) hold(0, r[k], CPB);
        #2 start = 1'b0;
        #1;
        check("arst_valid", 32'(valid0), 32'd0);
        check("arst_level", 32'(level0), 32'd0);
        check("arst_data", 32'(data0), 32'd0);
        check("arst_err", 32'({ferr0, perr0, ovr0}), 32'd0);
        rx0 = 1'b1;
        repeat (3) @(posedge clk);
        #1 start = 1'b1;
        out_ready = 1'b1;
        hold(0, 1'b1, CPB);
        mark();
        send_frame(0, 8'h81, 1'b0, 1'b0, 1'b1, 1, 2, -1);
        check("post_rst_beats", got0.size() - bg0, 1);
        check("post_rst_data", got_at(0, bg0), 32'h81);

        // Randomised 8E1 traffic with mixed faults and gaps
        mark();
        exp_f = 0;
        exp_p = 0;
        for (int i = 0; i < 24; i++) begin
            r = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 7);
            par = ^r;
            if (kind == 0 || kind == 2) par = ~par;
            stop_lvl = (kind == 1 || kind == 2) ? 1'b0 : 1'b1;
            idle = (stop_lvl == 1'b0) ? 1 : $urandom_range(0, 2);
            gb = -1;
`ifdef UART_RX_MAJORITY_EN
            if ($urandom_range(0, 2) == 0) gb = $urandom_range(0, DB - 1);
`endif
            if (stop_lvl == 1'b0) exp_f++;
            else if (par != ^r) exp_p++;
            else exp_q.push_back(r);
            send_frame(1, r, 1'b1, par, stop_lvl, 1, idle, gb);
        end
        hold(1, 1'b1, 2 * CPB);
        check("rand_beats", got1.size() - bg1, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check("rand_data", got_at(1, bg1 + i), 32'(exp_q[i]));
        end
        check("rand_framing", 32'(fcnt1 - bf1), 32'(exp_f));
        check("rand_parity", 32'(pcnt1 - bp1), 32'(exp_p));
        check("rand_overrun", 32'(ocnt1 - bo1), 32'd0);
        check("rand_level", 32'(level1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
